pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the pipeline.
- Each cycle it selects the next PC from three sources: sequential pc+4, a control-transfer target resolved in ID by the branch unit, or a latched pending target.
- Honours the single MIPS delay slot, hazard-unit stalls, multi-cycle instruction-memory responses and a halt request.
- Sits between the branch unit (ID stage), the hazard unit and the instruction-memory port feeding the IF/ID register.

Parameters:
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hazard-unit stall; holds PC and suppresses fetch completion.
- br_valid  in  1  one-cycle pulse: the ID instruction is a control transfer and br_target is valid.
- br_target  in  32  next PC after the delay slot, from the branch unit (already pc+8 when not taken).
- halt  in  1  level request to stop fetching.
- imem_ready  in  1  instruction memory has data for imem_addr this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= current PC).
- if_valid  out  1  fetch completed this cycle; IF/ID captures the instruction at if_pc.
- if_pc  out  32  PC of the completing fetch.
- halted  out  1  sequencer in HALTED.
- addr_err  out  1  sticky: a misaligned br_target was received.
- fetch_cnt  out  CNT_W  completed fetches.
- redirect_cnt  out  CNT_W  fetches whose next PC came from a target, not pc+4.

Behaviour:
- **Reset (async, immediate):**
  - pc=RESET_PC; state=BOOT.
  - pend_valid=0, pend_target=0.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=RESET_PC.
  - halted=0, addr_err=0, both counters 0.
  - Reset mid-fetch abandons the fetch with no completion.
- **States:**
  - BOOT: one cycle after reset release, imem_req=0, then goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
  - HALTED: imem_req=0, halted=1; exits only via rst.
- **Fetch completion:**
  - complete = state==FETCH & imem_ready & !stall. It is combinational.
  - if_valid=complete, if_pc=pc. No register delay: completion appears the same cycle as imem_ready.
  - imem_addr is stable while a fetch is outstanding; stall or !imem_ready holds pc unchanged.
  - If memory is ready during a stall, the data is discarded and the same address is re-presented.
- **Next PC on complete:**
  - If pend_valid: next = pend_target, then clear pend_valid.
  - Else if br_valid: next = br_target.
  - Else: next = pc+4, with mod 2^32 wrap (32'hFFFFFFFC -> 0).
  - redirect_cnt increments when next came from pend_target or br_target, even if the value equals pc+4.
  - fetch_cnt increments on every complete.
  - Both counters wrap.
- **Delay slot:** a branch in ID at cycle t is paired with the delay-slot fetch in IF. The fetch completing in the same cycle as br_valid, or the first one completing after it, is the delay slot. The PC following it is the target. Exactly one instruction is fetched between a branch and its target.
- **Pending latch:**
  - br_valid with !complete sets pend_valid=1, pend_target=br_target.
  - br_valid while pend_valid=1 is a protocol violation. The new pulse is ignored and the first target is retained.
- **Alignment:** any br_target with bits[1:0]!=0 sets addr_err. The target is used with bits[1:0] forced to 00.
- **Halt:**
  - In FETCH with halt=1, the transition to HALTED occurs on the next complete.
  - That fetch still delivers (if_valid=1), and pc and the counters update with it.
  - A pending target still applies to pc before halting.
  - halt in BOOT is deferred to FETCH.
- **Simultaneous halt + br_valid on a completing cycle:** pc=br_target, then HALTED.

Test Plan:
- Reset release, imem_ready=1 constant -> BOOT 1 cycle; if_pc sequence BFC00000, BFC00004, BFC00008; fetch_cnt=3; redirect_cnt=0.
- br_valid with br_target=BFC00100 on the cycle completing BFC00008 -> next if_pc=BFC00100; redirect_cnt=1.
- imem_ready=0 for 3 cycles while br_valid pulses (target 0x80000040) -> pend_valid set; imem_addr held; delay-slot fetch delivered; next if_pc=0x80000040.
- stall=1 for 2 cycles with imem_ready=1 -> if_valid=0; pc unchanged; counters frozen; after release the same address completes once.
- br_target=0x80000042 -> addr_err=1 (sticky); fetch address 0x80000040; pc wrap at FFFFFFFC -> 00000000.
- halt=1 with imem_ready low 2 cycles, then high -> one more if_valid, then halted=1 and imem_req=0; async rst mid-HALTED -> imem_addr=BFC00000 and halted=0 immediately.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch bus between the PC sequencer and the instruction memory / IF-ID register.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        if_valid;
  logic [31:0] if_pc;

  modport master (
    output imem_req,
    output imem_addr,
    output if_valid,
    output if_pc,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  if_valid,
    input  if_pc,
    output imem_ready
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: selects pc+4 / branch target / pending target and sequences fetch,
// honouring the delay slot, hazard stalls, slow instruction memory and halt.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 br_valid,
    input  logic [31:0]          br_target,
    input  logic                 halt,
    pc_sequencer_if.master       bus,
    output logic                 halted,
    output logic                 addr_err,
    output logic [CNT_W-1:0]     fetch_cnt,
    output logic [CNT_W-1:0]     redirect_cnt
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HALTED
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state;
    logic [31:0] pc;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        req_q;
    logic        halted_q;

    logic        complete;
    logic        redirect;
    logic [31:0] br_aligned;
    logic [31:0] next_pc;

    assign complete   = (state == S_FETCH) && bus.imem_ready && !stall;
    assign br_aligned = {br_target[31:2], 2'b00};

    // A latched target outranks a fresh pulse: a second branch before the first is consumed is dropped.
    always_comb begin
        redirect = pend_valid | br_valid;
        next_pc  = pc + 32'd4;
        if (pend_valid)
            next_pc = pend_target;
        else if (br_valid)
            next_pc = br_aligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            pend_valid   <= 1'b0;
            pend_target  <= '0;
            req_q        <= 1'b0;
            halted_q     <= 1'b0;
            addr_err     <= 1'b0;
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (br_valid && (br_target[1:0] != 2'b00))
                addr_err <= 1'b1;

            case (state)
                S_BOOT: begin
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
                S_FETCH: begin
                    if (complete) begin
                        pc         <= next_pc;
                        pend_valid <= 1'b0;
                        fetch_cnt  <= fetch_cnt + CNT_ONE;
                        if (redirect)
                            redirect_cnt <= redirect_cnt + CNT_ONE;
                        if (halt) begin
                            state    <= S_HALTED;
                            req_q    <= 1'b0;
                            halted_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Branch seen while the delay-slot fetch is still outstanding: hold its target.
            if (br_valid && !pend_valid && !complete) begin
                pend_valid  <= 1'b1;
                pend_target <= br_aligned;
            end
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc;
    assign bus.if_valid  = complete;
    assign bus.if_pc     = pc;
    assign halted        = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: boot, branches, pending target, stall,
// misalignment, wrap, halt and async reset.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        halt;
    logic        halted;
    logic        addr_err;
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;

    int unsigned checks;
    int unsigned errors;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC (32'hBFC00000),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .halt         (halt),
        .bus          (bus),
        .halted       (halted),
        .addr_err     (addr_err),
        .fetch_cnt    (fetch_cnt),
        .redirect_cnt (redirect_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic bv, input logic [31:0] bt,
                         input logic h, input logic rdy);
        stall          = s;
        br_valid       = bv;
        br_target      = bt;
        halt           = h;
        bus.imem_ready = rdy;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        check("rst_req",      {31'b0, bus.imem_req}, 32'h0);
        check("rst_addr",     bus.imem_addr,         32'hBFC00000);
        check("rst_ifvalid",  {31'b0, bus.if_valid}, 32'h0);
        check("rst_ifpc",     bus.if_pc,             32'hBFC00000);
        check("rst_halted",   {31'b0, halted},       32'h0);
        check("rst_adderr",   {31'b0, addr_err},     32'h0);
        check("rst_fcnt",     fetch_cnt,             32'h0);
        check("rst_rcnt",     redirect_cnt,          32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("boot_req",     {31'b0, bus.imem_req}, 32'h0);
        check("boot_ifvalid", {31'b0, bus.if_valid}, 32'h0);
        step(); #1;
        check("f0_req",       {31'b0, bus.imem_req}, 32'h1);
        check("f0_valid",     {31'b0, bus.if_valid}, 32'h1);
        check("f0_pc",        bus.if_pc,             32'hBFC00000);
        step(); #1;
        check("f1_pc",        bus.if_pc,             32'hBFC00004);
        step();
        drive(1'b0, 1'b1, 32'hBFC00100, 1'b0, 1'b1);
        #1;
        check("f2_pc",        bus.if_pc,             32'hBFC00008);
        check("f2_rcnt",      redirect_cnt,          32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        check("br_fcnt",      fetch_cnt,             32'd3);
        check("br_rcnt",      redirect_cnt,          32'd1);
        check("br_pc",        bus.if_pc,             32'hBFC00100);
        step();

        // Memory busy while the branch pulses: delay slot still BFC00104, then the target.
        drive(1'b0, 1'b1, 32'h80000040, 1'b0, 1'b0);
        #1;
        check("pend_valid0",  {31'b0, bus.if_valid}, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("pend_addr1",   bus.imem_addr,         32'hBFC00104);
        step(); #1;
        check("pend_addr2",   bus.imem_addr,         32'hBFC00104);
        step();
        bus.imem_ready = 1'b1;
        #1;
        check("slot_valid",   {31'b0, bus.if_valid}, 32'h1);
        check("slot_pc",      bus.if_pc,             32'hBFC00104);
        step(); #1;
        check("pend_tgt",     bus.if_pc,             32'h80000040);
        check("pend_fcnt",    fetch_cnt,             32'd5);
        check("pend_rcnt",    redirect_cnt,          32'd2);

        stall = 1'b1;
        #1;
        check("stall_valid0", {31'b0, bus.if_valid}, 32'h0);
        step(); #1;
        check("stall_valid1", {31'b0, bus.if_valid}, 32'h0);
        check("stall_addr",   bus.imem_addr,         32'h80000040);
        check("stall_fcnt",   fetch_cnt,             32'd5);
        step();
        stall = 1'b0;
        #1;
        check("unstall_pc",   bus.if_pc,             32'h80000040);
        check("unstall_val",  {31'b0, bus.if_valid}, 32'h1);
        step(); #1;
        check("unstall_next", bus.imem_addr,         32'h80000044);
        check("unstall_fcnt", fetch_cnt,             32'd6);

        drive(1'b0, 1'b1, 32'h80000042, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        check("mis_err",      {31'b0, addr_err},     32'h1);
        check("mis_addr",     bus.imem_addr,         32'h80000040);
        check("mis_rcnt",     redirect_cnt,          32'd3);
        step(); #1;
        check("mis_sticky",   {31'b0, addr_err},     32'h1);
        check("mis_next",     bus.imem_addr,         32'h80000044);
        br_valid  = 1'b1;
        br_target = 32'hFFFFFFFC;
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        check("wrap_top",     bus.if_pc,             32'hFFFFFFFC);
        step(); #1;
        check("wrap_zero",    bus.imem_addr,         32'h00000000);
        check("wrap_fcnt",    fetch_cnt,             32'd10);
        check("wrap_rcnt",    redirect_cnt,          32'd4);

        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        check("hlt_wait_v",   {31'b0, bus.if_valid}, 32'h0);
        step(); #1;
        check("hlt_wait_h",   {31'b0, halted},       32'h0);
        check("hlt_wait_req", {31'b0, bus.imem_req}, 32'h1);
        step();
        bus.imem_ready = 1'b1;
        #1;
        check("hlt_last_v",   {31'b0, bus.if_valid}, 32'h1);
        check("hlt_last_pc",  bus.if_pc,             32'h00000000);
        step(); #1;
        check("hlt_halted",   {31'b0, halted},       32'h1);
        check("hlt_req",      {31'b0, bus.imem_req}, 32'h0);
        check("hlt_ifvalid",  {31'b0, bus.if_valid}, 32'h0);
        check("hlt_pc",       bus.imem_addr,         32'h00000004);
        check("hlt_fcnt",     fetch_cnt,             32'd11);
        step(); #1;
        check("hlt_stay",     {31'b0, halted},       32'h1);
        rst = 1'b1;
        #1;
        check("arst_addr",    bus.imem_addr,         32'hBFC00000);
        check("arst_halted",  {31'b0, halted},       32'h0);
        check("arst_fcnt",    fetch_cnt,             32'h0);

        // Halt raised during BOOT waits for FETCH; halt + branch on one completion lands on the target.
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        check("bh_boot_req",  {31'b0, bus.imem_req}, 32'h0);
        step();
        br_valid  = 1'b1;
        br_target = 32'h00001000;
        #1;
        check("bh_not_halt",  {31'b0, halted},       32'h0);
        check("bh_req",       {31'b0, bus.imem_req}, 32'h1);
        check("bh_valid",     {31'b0, bus.if_valid}, 32'h1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        check("bh_halted",    {31'b0, halted},       32'h1);
        check("bh_addr",      bus.imem_addr,         32'h00001000);
        check("bh_rcnt",      redirect_cnt,          32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
